// File: rtl/conv_colgen.sv
// rtl/conv_colgen.sv - K-tall column generator over a circular line buffer with valid/ready handshake
module conv_colgen #(
    parameter int PIXEL_W  = 8,
    parameter int K        = 5,
    parameter int MAX_W    = 1024,
    parameter int PAD_MODE = 0,
    parameter int ROW_W    = 12
) (
    input  logic                     clk,
    input  logic                     arst,
    input  logic                     s_tvalid,
    input  logic [PIXEL_W-1:0]       s_tdata,
    input  logic                     s_tuser,
    input  logic                     s_tlast,
    output logic                     s_tready,
    output logic                     m_tvalid,
    input  logic                     m_tready,
    output logic [K*PIXEL_W-1:0]     m_tdata,
    output logic [K-1:0]             m_row_vld,
    output logic                     m_sof,
    output logic                     m_eol,
    output logic [$clog2(MAX_W)-1:0] m_col,
    output logic [ROW_W-1:0]         m_row,
    output logic                     err_o
);

    localparam int CW = $clog2(MAX_W);
    localparam int NL = K - 1;
    localparam int PW = (NL > 1) ? $clog2(NL) : 1;

    typedef enum logic {ST_IDLE, ST_FRAME} state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [PIXEL_W-1:0] r_mem [NL][MAX_W];
    logic [CW-1:0]      r_col;
    logic [ROW_W-1:0]   r_row;
    logic [PW-1:0]      r_ptr;
    logic               r_learnt;
    logic [CW:0]        r_w;
    logic               r_ovf;
    logic               r_err;

    logic               w_acc;
    logic               w_take;
    logic [CW-1:0]      w_col;
    logic [ROW_W-1:0]   w_row;
    logic [PW-1:0]      w_ptr;
    logic               w_learnt;
    logic               w_ovf;
    logic               w_last_col;
    logic               w_len_err;
    logic [ROW_W-1:0]   w_row_eff;
    logic [PIXEL_W-1:0] w_raw [K];
    logic [PIXEL_W-1:0] w_pad_src;
    logic [K-1:0]       w_row_vld;
    logic [K*PIXEL_W-1:0] w_col_data;

    // Slot that holds row y-i when row y is being written into slot ptr.
    function automatic logic [PW-1:0] slot_of(input logic [PW-1:0] ptr, input int i);
        int s;
        s = int'(ptr) + NL - i;
        if (s >= NL) s = s - NL;
        return PW'(s);
    endfunction

    assign s_tready = ~m_tvalid | m_tready;
    assign w_acc    = s_tvalid & s_tready;
    assign w_take   = w_acc & (s_tuser | (r_state == ST_FRAME));
    assign err_o    = r_err;

    // A start-of-frame pixel sees freshly restarted counters.
    assign w_col      = s_tuser ? '0 : r_col;
    assign w_row      = s_tuser ? '0 : r_row;
    assign w_ptr      = s_tuser ? '0 : r_ptr;
    assign w_learnt   = s_tuser ? 1'b0 : r_learnt;
    assign w_ovf      = ~s_tuser & (r_ovf | (r_learnt & ({1'b0, r_col} >= r_w)));
    assign w_last_col = (w_col == CW'(MAX_W - 1));
    assign w_len_err  = w_learnt & s_tlast & ({1'b0, w_col} != (r_w - (CW+1)'(1)));
    // An over-long pixel is emitted as if it were on the top row: only itself is valid.
    assign w_row_eff  = w_ovf ? '0 : w_row;

    // Assemble the column: current pixel plus buffered rows, padding rows above the frame top.
    always_comb begin
        w_raw[0] = s_tdata;
        for (int i = 1; i < K; i++) begin
            w_raw[i] = r_mem[slot_of(w_ptr, i)][w_col];
        end
        w_pad_src = '0;
        for (int j = 0; j < K; j++) begin
            if (ROW_W'(j) == w_row_eff) w_pad_src = w_raw[j];
        end
        w_row_vld  = '0;
        w_col_data = '0;
        for (int i = 0; i < K; i++) begin
            w_row_vld[i] = (ROW_W'(i) <= w_row_eff);
            if (w_row_vld[i])
                w_col_data[i*PIXEL_W +: PIXEL_W] = w_raw[i];
            else if (PAD_MODE == 1)
                w_col_data[i*PIXEL_W +: PIXEL_W] = w_pad_src;
            else
                w_col_data[i*PIXEL_W +: PIXEL_W] = '0;
        end
    end

    // Line buffer write; reads above see the old contents of the same slot.
    always_ff @(posedge clk) begin
        if (w_take && !w_ovf) r_mem[w_ptr][w_col] <= s_tdata;
    end

    // Frame state register.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) r_state <= ST_IDLE;
        else      r_state <= w_state_nxt;
    end

    // Any accepted start-of-frame pixel enters (or restarts) a frame.
    always_comb begin
        w_state_nxt = r_state;
        if (w_acc && s_tuser) w_state_nxt = ST_FRAME;
    end

    // Column/row counters, learnt width and sticky line-length error.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_col    <= '0;
            r_row    <= '0;
            r_ptr    <= '0;
            r_learnt <= 1'b0;
            r_w      <= '0;
            r_ovf    <= 1'b0;
            r_err    <= 1'b0;
        end else if (w_take) begin
            if (s_tlast) begin
                r_col    <= '0;
                r_ovf    <= 1'b0;
                r_row    <= (&w_row) ? w_row : w_row + ROW_W'(1);
                r_ptr    <= (w_ptr == PW'(NL - 1)) ? '0 : w_ptr + PW'(1);
                r_learnt <= 1'b1;
                if (!w_learnt) r_w <= {1'b0, w_col} + (CW+1)'(1);
            end else begin
                r_row    <= w_row;
                r_ptr    <= w_ptr;
                r_learnt <= w_learnt;
                if (w_last_col) begin
                    r_col <= w_col;
                    r_ovf <= 1'b1;
                end else begin
                    r_col <= w_col + CW'(1);
                    r_ovf <= 1'b0;
                end
            end
            if (w_ovf || w_len_err) r_err <= 1'b1;
        end
    end

    // Single output register: load on take, release once the consumer accepts.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            m_tvalid  <= 1'b0;
            m_tdata   <= '0;
            m_row_vld <= '0;
            m_sof     <= 1'b0;
            m_eol     <= 1'b0;
            m_col     <= '0;
            m_row     <= '0;
        end else if (w_take) begin
            m_tvalid  <= 1'b1;
            m_tdata   <= w_col_data;
            m_row_vld <= w_row_vld;
            m_sof     <= s_tuser;
            m_eol     <= s_tlast;
            m_col     <= w_col;
            m_row     <= w_row;
        end else if (m_tready) begin
            m_tvalid  <= 1'b0;
        end
    end

endmodule
